// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack memory bus between fetch and data requesters,
// alternating under contention and aborting accesses that never see mem_ack.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO_CYC = 255,
  parameter int TO_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          me_rd,
  input  logic          me_wr,
  input  logic [AW-1:0] me_addr,
  input  logic [DW-1:0] me_wdata,
  output logic [DW-1:0] me_rdata,
  output logic          me_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err,
  output logic          arb_stall
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_ME, DONE} state_t;
  state_t state;
  logic lastMe;
  logic [TO_W-1:0] toCnt;
  logic mePend, grantMe, timeout;
  assign mePend = me_rd | me_wr;
  // data wins unless fetch is also waiting and data had the previous grant
  assign grantMe = mePend & (~if_req | ~lastMe);
  assign timeout = toCnt == TO_W'(TO_CYC - 1);
  assign arb_stall = (if_req & ~if_ready) | (mePend & ~me_ready);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      lastMe <= 1'b0;
      toCnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      me_rdata <= '0;
      if_ready <= 1'b0;
      me_ready <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mePend | if_req) begin
          state <= grantMe ? BUSY_ME : BUSY_IF;
          lastMe <= grantMe;
          mem_req <= 1'b1;
          mem_we <= grantMe & me_wr;
          mem_addr <= grantMe ? me_addr : if_addr;
          mem_wdata <= grantMe ? me_wdata : mem_wdata;
          toCnt <= '0;
        end
        BUSY_IF, BUSY_ME: if (mem_ack | timeout) begin
          state <= DONE;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          bus_err <= ~mem_ack;
          if_ready <= state == BUSY_IF;
          me_ready <= state == BUSY_ME;
          // an aborted read returns all-ones; a store never touches me_rdata
          if (state == BUSY_IF) if_rdata <= mem_ack ? mem_rdata : '1;
          else if (!mem_we) me_rdata <= mem_ack ? mem_rdata : '1;
        end else toCnt <= toCnt + 1'b1;
        default: begin
          state <= IDLE;
          if_ready <= 1'b0;
          me_ready <= 1'b0;
          bus_err <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus randomized traffic checked against a
// transaction-level model of grant order, latency and memory contents.
module tb_mem_arbiter;
  localparam int TO = 255;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, me_rd = 1'b0, me_wr = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, me_addr = '0, me_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata;
  logic if_ready, me_ready, mem_req, mem_we, bus_err, arb_stall;

  mem_arbiter #(.AW(32), .DW(32), .TO_CYC(TO), .TO_W(8)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .me_rd(me_rd), .me_wr(me_wr), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_rdata(me_rdata), .me_ready(me_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .arb_stall(arb_stall)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  bit [31:0] rspMem [bit [31:0]];
  bit [31:0] refMem [bit [31:0]];
  bit [31:0] refIfData, refMeData;
  bit refLastMe;

  typedef struct {bit [31:0] addr; bit [31:0] wdata; bit we; bit stable; int first; int len;} burst_t;
  burst_t bursts[$];
  int ifRdyCyc, meRdyCyc, ifPulses, mePulses, errPulses, stallBad;
  bit [31:0] ifData, meData;
  bit ifErr, meErr, finished;

  function automatic bit [31:0] seed(bit [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit [31:0] refRead(bit [31:0] a);
    return refMem.exists(a) ? refMem[a] : seed(a);
  endfunction

  // Drives the requested accesses, plays the memory side (ack on the delay-th
  // request cycle, never if delay is 0) and records what the DUT did.
  task automatic run(input bit doIf, input bit doMe, input bit wr, input bit [31:0] ia,
                     input bit [31:0] ma, input bit [31:0] wd, input int delay, input bit extraAck);
    int len, idle;
    bit ackPrev;
    burst_t b;
    bursts.delete();
    ifRdyCyc = -1; meRdyCyc = -1; ifPulses = 0; mePulses = 0; errPulses = 0; stallBad = 0;
    ifErr = 0; meErr = 0; finished = 0; len = 0; idle = 0; b = '{default: 0};
    if_req = doIf; if_addr = ia; me_rd = doMe & ~wr; me_wr = doMe & wr; me_addr = ma; me_wdata = wd;
    mem_ack = 0;
    #1 if (arb_stall !== (doIf | doMe)) stallBad++;
    for (int cyc = 1; cyc < 700; cyc++) begin
      @(negedge clock);
      ackPrev = mem_ack;
      mem_ack = 0;
      if (if_ready) begin ifPulses++; ifRdyCyc = cyc; ifData = if_rdata; ifErr = bus_err; end
      if (me_ready) begin mePulses++; meRdyCyc = cyc; meData = me_rdata; meErr = bus_err; end
      if (bus_err) errPulses++;
      if (arb_stall !== ((if_req & ~if_ready) | ((me_rd | me_wr) & ~me_ready))) stallBad++;
      if (mem_req) begin
        if (len == 0) begin b.addr = mem_addr; b.we = mem_we; b.wdata = mem_wdata; b.first = cyc; b.stable = 1; end
        len++;
        if (mem_addr !== b.addr || mem_we !== b.we || (mem_we && mem_wdata !== b.wdata)) b.stable = 0;
        if (len == delay) begin
          mem_ack = 1;
          mem_rdata = rspMem.exists(mem_addr) ? rspMem[mem_addr] : seed(mem_addr);
          if (mem_we) rspMem[mem_addr] = mem_wdata;
        end
      end else begin
        if (len > 0) begin b.len = len; bursts.push_back(b); len = 0; end
        if (extraAck && ackPrev) begin mem_ack = 1; mem_rdata = ~mem_rdata; end
      end
      if (if_ready) if_req = 0;
      if (me_ready) begin me_rd = 0; me_wr = 0; end
      if (!if_req && !me_rd && !me_wr) idle++;
      if (idle == 4) begin finished = 1; break; end
    end
    if (len > 0) begin b.len = len; bursts.push_back(b); end
    mem_ack = 0;
  endtask

  task automatic apply_reset();
    reset = 1; if_req = 0; me_rd = 0; me_wr = 0; mem_ack = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    refIfData = 0; refMeData = 0; refLastMe = 0;
  endtask

  task automatic test_reset();
    reset = 1; me_rd = 1; me_addr = 32'h10000000;
    @(negedge clock); @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if ({mem_we, if_ready, me_ready, bus_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {mem_we, if_ready, me_ready, bus_err}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({if_rdata, me_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {if_rdata, me_rdata}); end
    checks++; if (arb_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_pending got %b want 1", arb_stall); end
    me_rd = 0;
    #1 checks++; if (arb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", arb_stall); end
    apply_reset();
  endtask

  task automatic test_fetch();
    rspMem[32'h00400000] = 32'h8C220004; refMem[32'h00400000] = 32'h8C220004;
    run(1, 0, 0, 32'h00400000, 0, 0, 2, 0);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL fetch_done got %b want 1", finished); end
    checks++; if (bursts.size() !== 1) begin errors++; $display("FAIL fetch_bursts got %0d want 1", bursts.size()); end
    else begin
      checks++; if (bursts[0].first !== 1) begin errors++; $display("FAIL fetch_req_cycle got %0d want 1", bursts[0].first); end
      checks++; if ({bursts[0].we, bursts[0].stable, bursts[0].addr} !== {2'b01, 32'h00400000}) begin errors++; $display("FAIL fetch_bus we/stable/addr got %b/%b/%h want 0/1/00400000", bursts[0].we, bursts[0].stable, bursts[0].addr); end
    end
    checks++; if (ifRdyCyc !== 3) begin errors++; $display("FAIL fetch_ready_cycle got %0d want 3", ifRdyCyc); end
    checks++; if (ifData !== 32'h8C220004) begin errors++; $display("FAIL fetch_rdata got %h want 8c220004", ifData); end
    checks++; if ({ifPulses, mePulses, errPulses, stallBad} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL fetch_pulses if/me/err/stallbad got %0d/%0d/%0d/%0d want 1/0/0/0", ifPulses, mePulses, errPulses, stallBad); end
    refIfData = 32'h8C220004; refLastMe = 0;
  endtask

  task automatic test_write();
    run(0, 1, 1, 0, 32'h10010000, 32'hDEADBEEF, 4, 0);
    checks++; if (bursts.size() !== 1) begin errors++; $display("FAIL write_bursts got %0d want 1", bursts.size()); end
    else begin
      checks++; if ({bursts[0].we, bursts[0].stable, bursts[0].wdata} !== {2'b11, 32'hDEADBEEF}) begin errors++; $display("FAIL write_bus we/stable/wdata got %b/%b/%h want 1/1/deadbeef", bursts[0].we, bursts[0].stable, bursts[0].wdata); end
      checks++; if (bursts[0].len !== 4) begin errors++; $display("FAIL write_len got %0d want 4", bursts[0].len); end
    end
    checks++; if ({meRdyCyc, mePulses} !== {32'd5, 32'd1}) begin errors++; $display("FAIL write_ready cycle/pulses got %0d/%0d want 5/1", meRdyCyc, mePulses); end
    checks++; if (me_rdata !== refMeData) begin errors++; $display("FAIL write_rdata_kept got %h want %h", me_rdata, refMeData); end
    checks++; if (stallBad !== 0) begin errors++; $display("FAIL write_stall got %0d bad cycles want 0", stallBad); end
    refMem[32'h10010000] = 32'hDEADBEEF; refLastMe = 1;
  endtask

  task automatic test_alternation();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      run(1, 1, 0, 32'h00400020 + 32'(r), 32'h10010000, 0, 1, 0);
      checks++; if (bursts.size() !== 2) begin errors++; $display("FAIL alt_bursts round %0d got %0d want 2", r, bursts.size()); end
      else begin
        checks++; if ({bursts[0].addr, bursts[1].addr} !== {32'h10010000, 32'h00400020 + 32'(r)}) begin errors++; $display("FAIL alt_order round %0d got %h,%h want ME then IF", r, bursts[0].addr, bursts[1].addr); end
      end
      checks++; if ({meRdyCyc, ifRdyCyc, mePulses, ifPulses} !== {32'd2, 32'd5, 32'd1, 32'd1}) begin errors++; $display("FAIL alt_ready round %0d me/if cyc %0d/%0d pulses %0d/%0d want 2/5 1/1", r, meRdyCyc, ifRdyCyc, mePulses, ifPulses); end
      checks++; if (meData !== 32'hDEADBEEF) begin errors++; $display("FAIL alt_me_rdata got %h want deadbeef", meData); end
    end
    refMeData = 32'hDEADBEEF; refIfData = refRead(32'h00400021); refLastMe = 0;
  endtask

  task automatic test_timeout();
    run(0, 1, 0, 0, 32'h10020000, 0, 0, 0);
    checks++; if (bursts.size() !== 1 || bursts[0].len !== TO) begin errors++; $display("FAIL timeout_len got %0d bursts len %0d want 1 len %0d", bursts.size(), bursts.size() ? bursts[0].len : 0, TO); end
    checks++; if ({meRdyCyc, mePulses} !== {32'(TO + 1), 32'd1}) begin errors++; $display("FAIL timeout_ready cyc/pulses got %0d/%0d want %0d/1", meRdyCyc, mePulses, TO + 1); end
    checks++; if ({meErr, errPulses} !== {1'b1, 32'd1}) begin errors++; $display("FAIL timeout_bus_err got %b x%0d want 1 x1", meErr, errPulses); end
    checks++; if (meData !== 32'hFFFFFFFF) begin errors++; $display("FAIL timeout_rdata got %h want ffffffff", meData); end
    refMeData = 32'hFFFFFFFF; refLastMe = 1;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    if_req = 1; if_addr = 32'h00400010; me_rd = 0; me_wr = 0; mem_ack = 0;
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", mem_req); end
    me_rd = 1; me_addr = 32'h10000008;
    #2 reset = 1;
    #1 checks++; if ({mem_req, mem_addr, if_ready} !== 34'h0) begin errors++; $display("FAIL rstmid_async got req %b addr %h want 0", mem_req, mem_addr); end
    @(negedge clock);
    reset = 0; refIfData = 0; refMeData = 0; refLastMe = 0;
    run(1, 1, 0, 32'h00400010, 32'h10000008, 0, 2, 0);
    checks++; if (bursts.size() < 1 || bursts[0].addr !== 32'h10000008) begin errors++; $display("FAIL rstmid_order got %0d bursts first %h want 10000008", bursts.size(), bursts.size() ? bursts[0].addr : 0); end
    checks++; if ({meRdyCyc, ifRdyCyc} !== {32'd3, 32'd7}) begin errors++; $display("FAIL rstmid_ready me/if got %0d/%0d want 3/7", meRdyCyc, ifRdyCyc); end
    checks++; if ({meData, ifData} !== {refRead(32'h10000008), refRead(32'h00400010)}) begin errors++; $display("FAIL rstmid_rdata got %h/%h want %h/%h", meData, ifData, refRead(32'h10000008), refRead(32'h00400010)); end
    refMeData = refRead(32'h10000008); refIfData = refRead(32'h00400010); refLastMe = 0;
  endtask

  task automatic test_spurious();
    int hits = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1; mem_rdata = $urandom;
      @(negedge clock);
      hits += int'(if_ready | me_ready | mem_req | bus_err);
    end
    mem_ack = 0;
    checks++; if (hits !== 0) begin errors++; $display("FAIL spurious_idle got %0d active cycles want 0", hits); end
    checks++; if ({if_rdata, me_rdata} !== {refIfData, refMeData}) begin errors++; $display("FAIL spurious_idle_data got %h/%h want %h/%h", if_rdata, me_rdata, refIfData, refMeData); end
    run(0, 1, 0, 0, 32'h10000004, 0, 3, 1);
    refMeData = refRead(32'h10000004); refLastMe = 1;
    checks++; if ({meRdyCyc, mePulses} !== {32'd4, 32'd1}) begin errors++; $display("FAIL spurious_done_ready cyc/pulses got %0d/%0d want 4/1", meRdyCyc, mePulses); end
    checks++; if (me_rdata !== refMeData) begin errors++; $display("FAIL spurious_done_data got %h want %h", me_rdata, refMeData); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int mode, d, expIf, expMe;
      bit doIf, doMe, wr, meFirst;
      bit [31:0] ia, ma, wd;
      mode = $urandom_range(0, 2); doIf = mode != 1; doMe = mode != 0;
      wr = 1'($urandom_range(0, 1)); d = $urandom_range(1, 5); wd = $urandom;
      ia = 32'h00400000 + 4 * $urandom_range(0, 15);
      ma = 32'h10000000 + 4 * $urandom_range(0, 7);
      meFirst = doMe && (!doIf || !refLastMe);
      expMe = !doMe ? -1 : (meFirst ? d + 1 : 2 * d + 3);
      expIf = !doIf ? -1 : (meFirst ? 2 * d + 3 : d + 1);
      if (doIf) refIfData = refRead(ia);
      if (doMe && !wr) refMeData = refRead(ma);
      run(doIf, doMe, wr, ia, ma, wd, d, 0);
      if (doMe && wr) refMem[ma] = wd;
      refLastMe = (doIf && doMe) ? !meFirst : doMe;
      checks++; if ({ifRdyCyc, meRdyCyc} !== {expIf, expMe}) begin errors++; $display("FAIL rand%0d_ready if/me got %0d/%0d want %0d/%0d", n, ifRdyCyc, meRdyCyc, expIf, expMe); end
      checks++; if (bursts.size() !== int'(doIf) + int'(doMe) || bursts[0].addr !== (meFirst ? ma : ia)) begin errors++; $display("FAIL rand%0d_grant got %0d bursts first %h want %0d first %h", n, bursts.size(), bursts.size() ? bursts[0].addr : 0, int'(doIf) + int'(doMe), meFirst ? ma : ia); end
      checks++; if ({if_rdata, me_rdata} !== {refIfData, refMeData}) begin errors++; $display("FAIL rand%0d_data got %h/%h want %h/%h", n, if_rdata, me_rdata, refIfData, refMeData); end
      checks++; if ({ifPulses, mePulses, errPulses, stallBad} !== {32'(doIf), 32'(doMe), 32'd0, 32'd0}) begin errors++; $display("FAIL rand%0d_pulses if/me/err/stallbad got %0d/%0d/%0d/%0d", n, ifPulses, mePulses, errPulses, stallBad); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_alternation();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
